// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard pins plus the decoded key outputs handed to the display stage.
// bit_cnt exposes the deframer position (0..10) for observation.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       isRelease;
  logic       isExtend;
  logic       key_valid;
  logic [7:0] key_cnt;
  logic       frame_err;
  logic [3:0] bit_cnt;

  // key_valid and frame_err are single-cycle strobes with no back-pressure:
  // the consumer must sample code/isRelease/isExtend on the key_valid cycle
  // or later (they hold until the next strobe).
  modport master (
    input  ps2_clk, ps2_data,
    output code, isRelease, isExtend, key_valid, key_cnt, frame_err, bit_cnt
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  code, isRelease, isExtend, key_valid, key_cnt, frame_err, bit_cnt
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver: synchronises the pins, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and counts distinct key presses.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic clrn,
  ps2_key_decoder_if.master kb
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  logic          s0, s1, s2;
  logic          d0, d1;
  logic          fall;
  logic [3:0]    cnt;
  logic [9:0]    sr;
  logic [TW-1:0] tcnt;
  logic          ext_f, brk_f;
  logic          held_v;
  logic [7:0]    held;
  logic [7:0]    code_q, key_cnt_q;
  logic          rel_q, ext_q, key_valid_q, frame_err_q;
  logic [7:0]    rx_byte;
  logic          frame_ok;

  assign fall     = s2 & ~s1;
  // After ten shifts sr[0] is the start bit, sr[8:1] the data, sr[9] parity;
  // the stop bit is still sitting in d1 when the eleventh fall arrives.
  assign rx_byte  = sr[8:1];
  assign frame_ok = ~sr[0] & (^sr[9:1]) & d1;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s0 <= 1'b1; s1 <= 1'b1; s2 <= 1'b1;
      d0 <= 1'b1; d1 <= 1'b1;
      cnt <= 4'd0; sr <= 10'd0; tcnt <= '0;
      ext_f <= 1'b0; brk_f <= 1'b0;
      held_v <= 1'b0; held <= 8'd0;
      code_q <= 8'd0; rel_q <= 1'b0; ext_q <= 1'b0;
      key_valid_q <= 1'b0; frame_err_q <= 1'b0; key_cnt_q <= 8'd0;
    end else begin
      s0 <= kb.ps2_clk; s1 <= s0; s2 <= s1;
      d0 <= kb.ps2_data; d1 <= d0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (cnt != 4'd10) begin
          sr  <= {d1, sr[9:1]};
          cnt <= cnt + 4'd1;
        end else begin
          cnt <= 4'd0;
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext_f <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_f <= 1'b1;
          end else begin
            code_q      <= rx_byte;
            rel_q       <= brk_f;
            ext_q       <= ext_f;
            key_valid_q <= 1'b1;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            // Typematic repeats of the held key are not new presses.
            if (brk_f) begin
              if (held_v && held == rx_byte) held_v <= 1'b0;
            end else if (!held_v || held != rx_byte) begin
              key_cnt_q <= key_cnt_q + 8'd1;
              held      <= rx_byte;
              held_v    <= 1'b1;
            end
          end
        end
      end else if (cnt == 4'd0) begin
        tcnt <= '0;
      end else if (tcnt == T_LAST) begin
        tcnt        <= '0;
        cnt         <= 4'd0;
        frame_err_q <= 1'b1;
        ext_f       <= 1'b0;
        brk_f       <= 1'b0;
      end else begin
        tcnt <= tcnt + T_ONE;
      end
    end
  end

  assign kb.code      = code_q;
  assign kb.isRelease = rel_q;
  assign kb.isExtend  = ext_q;
  assign kb.key_valid = key_valid_q;
  assign kb.key_cnt   = key_cnt_q;
  assign kb.frame_err = frame_err_q;
  assign kb.bit_cnt   = cnt;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames, predicts decoded
// events from scan-code rules, and compares the DUT every cycle.
module tb_ps2_key_decoder;
  localparam int HALF = 8;
  localparam int GAP  = 12;
  localparam int EW   = 19;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  ps2_key_decoder_if kb();

  ps2_key_decoder #(.TIMEOUT_CYC(100)) dut (
    .clk  (clk),
    .clrn (clrn),
    .kb   (kb)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int last_fall = 0;

  // Event word: {err, release, extend, code[7:0], key_cnt[7:0]}
  logic [EW-1:0] exp_q[$];

  // Prediction state (protocol level) and the currently expected outputs.
  logic       p_ext = 0, p_brk = 0, p_held_v = 0;
  logic [7:0] p_held = 0, p_cnt = 0;
  logic [7:0] m_code = 0, m_cnt = 0;
  logic       m_rel = 0, m_extd = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic predict(input logic [7:0] b, input logic bad);
    if (bad) begin
      exp_q.push_back({1'b1, 18'd0});
      p_ext = 0; p_brk = 0;
    end else if (b == 8'hE0) begin
      p_ext = 1;
    end else if (b == 8'hF0) begin
      p_brk = 1;
    end else begin
      if (p_brk) begin
        if (p_held_v && p_held == b) p_held_v = 0;
      end else if (!(p_held_v && p_held == b)) begin
        p_cnt    = p_cnt + 8'd1;
        p_held   = b;
        p_held_v = 1;
      end
      exp_q.push_back({1'b0, p_brk, p_ext, b, p_cnt});
      p_ext = 0; p_brk = 0;
    end
  endtask

  task automatic send_raw(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      kb.ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      kb.ps2_clk = 1'b0;
      last_fall  = cyc;
      repeat (HALF) @(negedge clk);
      kb.ps2_clk = 1'b1;
    end
    repeat (GAP) @(negedge clk);
    kb.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    logic p;
    p = (~^b) ^ bad;
    predict(b, bad);
    send_raw({1'b1, p, b, 1'b0}, 11);
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    p_ext = 0; p_brk = 0; p_held_v = 0; p_held = 0; p_cnt = 0;
    m_code = 0; m_cnt = 0; m_rel = 0; m_extd = 0;
    exp_q.delete();
    kb.ps2_clk  = 1'b1;
    kb.ps2_data = 1'b1;
    #1;
    chk("rst_code", kb.code, 0);
    chk("rst_flags", {kb.isRelease, kb.isExtend, kb.key_valid, kb.frame_err}, 0);
    chk("rst_cnt", kb.key_cnt, 0);
    chk("rst_bitcnt", kb.bit_cnt, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
  endtask

  // Per-cycle compare against the predicted event stream.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      chk("strobe_exclusive", kb.key_valid & kb.frame_err, 0);
      if (kb.key_valid || kb.frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {kb.key_valid, kb.frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", kb.frame_err, e[18]);
          if (!e[18]) begin
            m_rel = e[17]; m_extd = e[16]; m_code = e[15:8]; m_cnt = e[7:0];
            chk("latency", cyc - last_fall, 3);
          end
        end
      end
      chk("code", kb.code, m_code);
      chk("isRelease", kb.isRelease, m_rel);
      chk("isExtend", kb.isExtend, m_extd);
      chk("key_cnt", kb.key_cnt, m_cnt);
    end
  end

  initial begin
    clrn = 1'b0;
    kb.ps2_clk  = 1'b1;
    kb.ps2_data = 1'b1;
    @(negedge clk);
    apply_reset();

    send_frame(8'h1C, 0);
    chk("t1_code", kb.code, 8'h1C);
    chk("t1_cnt", kb.key_cnt, 8'd1);
    chk("t1_rel", kb.isRelease, 0);

    repeat (3) send_frame(8'h1C, 0);
    chk("typematic_cnt", kb.key_cnt, 8'd1);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    chk("break_rel", kb.isRelease, 1);
    chk("break_code", kb.code, 8'h1C);
    send_frame(8'h1C, 0);
    chk("repress_cnt", kb.key_cnt, 8'd2);

    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    chk("ext_make", {kb.isExtend, kb.isRelease, kb.code}, {2'b10, 8'h75});
    chk("ext_cnt", kb.key_cnt, 8'd3);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    chk("ext_break", {kb.isExtend, kb.isRelease, kb.code}, {2'b11, 8'h75});

    send_frame(8'hF0, 0);
    send_frame(8'h1C, 1);
    chk("bad_code_hold", kb.code, 8'h75);
    send_frame(8'h1C, 0);
    chk("bad_flag_drop", {kb.isRelease, kb.isExtend, kb.code}, {2'b00, 8'h1C});
    chk("bad_cnt", kb.key_cnt, 8'd4);

    exp_q.push_back({1'b1, 18'd0});
    p_ext = 0; p_brk = 0;
    send_raw(11'b101_0101_0100, 5);
    repeat (150) @(negedge clk);
    chk("timeout_bitcnt", kb.bit_cnt, 0);
    chk("timeout_seen", exp_q.size(), 0);
    send_frame(8'h2A, 0);
    chk("after_timeout", kb.code, 8'h2A);
    chk("after_timeout_cnt", kb.key_cnt, 8'd5);

    apply_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame((i % 2 == 1) ? 8'h32 : 8'h1C, 0);
      if (i == 254) chk("cnt_255", kb.key_cnt, 8'd255);
    end
    chk("cnt_wrap", kb.key_cnt, 8'd0);

    send_raw(11'b111_0000_1110, 4);
    chk("mid_bitcnt", kb.bit_cnt, 4);
    apply_reset();
    send_frame(8'h2A, 0);
    chk("post_rst", {kb.isRelease, kb.isExtend, kb.code}, {2'b00, 8'h2A});
    chk("post_rst_cnt", kb.key_cnt, 8'd1);

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
